// File: rtl/streamcalc_pkg.sv
// Shared opcode constants, default widths and the issuer state encoding for the stream calculator.
package streamcalc_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int OP_W_DEF   = 3;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_DIV  = 3'd3;
    localparam logic [2:0] OP_FDIV = 3'd4;
    localparam logic [2:0] OP_PUSH = 3'd5;
    localparam logic [2:0] OP_POP  = 3'd6;
    localparam logic [2:0] OP_BAD  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } iss_state_e;

endpackage

// File: rtl/streamcalc_cmd_fifo.sv
// Command FIFO: synchronous write/read, read data is the head entry (show-ahead), 0-cycle read latency.
// Writes are dropped when full and reads when empty; the caller owns the ready/valid handshake.
module streamcalc_cmd_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_dat_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_dat_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic             wr_fire;
    logic             rd_fire;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty_o  = (wr_ptr_q == rd_ptr_q);
    assign full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign wr_fire  = wr_en_i && !full_o;
    assign rd_fire  = rd_en_i && !empty_o;
    assign rd_dat_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (rd_fire) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_dat_i;
        end
    end

endmodule

// File: rtl/streamcalc_issuer.sv
// Issuer: queues host (op,data) commands and runs them one at a time through the calculator; apply 1 cycle after accept.
// Response is registered 1 cycle after calc_valid; cmd_ready = !full, and no new apply while a response awaits rsp_ready.
module streamcalc_issuer
    import streamcalc_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int OP_W    = OP_W_DEF,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              calc_apply,
    output logic [OP_W-1:0]   calc_op,
    output logic [DATA_W-1:0] calc_in,
    input  logic              calc_valid,
    input  logic              calc_err,
    input  logic [DATA_W-1:0] calc_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [OP_W-1:0]   rsp_op,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              busy
);

    localparam int CNT_W = $clog2(TIMEOUT);
    // The counter reaches TIMEOUT-1 on the increment out of this value, so the
    // response window closes TIMEOUT cycles after the apply cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

    iss_state_e              state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    apply_q;
    logic [OP_W-1:0]         op_q;
    logic [DATA_W-1:0]       in_q;
    logic                    rsp_vld_q;
    logic [OP_W-1:0]         rsp_op_q;
    logic [DATA_W-1:0]       rsp_dat_q;
    logic                    rsp_err_q;
    logic                    rsp_to_q;

    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_rd;
    logic [OP_W+DATA_W-1:0]  fifo_rd_dat;

    assign fifo_rd = (state_q == ST_IDLE);

    streamcalc_cmd_fifo #(
        .WIDTH (OP_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en_i  (cmd_valid),
        .wr_dat_i ({cmd_op, cmd_data}),
        .rd_en_i  (fifo_rd),
        .rd_dat_o (fifo_rd_dat),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            apply_q   <= 1'b0;
            op_q      <= '0;
            in_q      <= '0;
            rsp_vld_q <= 1'b0;
            rsp_op_q  <= '0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
            rsp_to_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        {op_q, in_q} <= fifo_rd_dat;
                        apply_q      <= 1'b1;
                        state_q      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    apply_q <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (calc_valid) begin
                        rsp_vld_q <= 1'b1;
                        rsp_op_q  <= op_q;
                        rsp_dat_q <= calc_out;
                        rsp_err_q <= calc_err;
                        rsp_to_q  <= 1'b0;
                        state_q   <= ST_RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        rsp_vld_q <= 1'b1;
                        rsp_op_q  <= op_q;
                        rsp_dat_q <= '0;
                        rsp_err_q <= 1'b0;
                        rsp_to_q  <= 1'b1;
                        state_q   <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_vld_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready   = !fifo_full;
    assign calc_apply  = apply_q;
    assign calc_op     = op_q;
    assign calc_in     = in_q;
    assign rsp_valid   = rsp_vld_q;
    assign rsp_op      = rsp_op_q;
    assign rsp_data    = rsp_dat_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_to_q;
    assign busy        = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_streamcalc_issuer.sv
// Bench for streamcalc_issuer: a calculator stub answers each apply after a planned delay,
// and a queue-based model predicts the host-side response of every command.
`timescale 1ns/1ps
module tb_streamcalc_issuer;
    import streamcalc_pkg::*;

    localparam int DW = 8;
    localparam int OW = 3;
    localparam int DEPTH = 4;
    localparam int TIMEOUT = 16;
    localparam logic [27:0] RST_VEC = 28'h800_0000;

    typedef struct packed {logic [2:0] op; logic [7:0] data;} cmd_t;
    typedef struct packed {logic [2:0] op; logic [7:0] data; logic err; logic to;} rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          cmd_valid, cmd_ready;
    logic [OW-1:0] cmd_op;
    logic [DW-1:0] cmd_data;
    logic          calc_apply;
    logic [OW-1:0] calc_op;
    logic [DW-1:0] calc_in;
    logic          calc_valid, calc_err;
    logic [DW-1:0] calc_out;
    logic          rsp_valid, rsp_ready;
    logic [OW-1:0] rsp_op;
    logic [DW-1:0] rsp_data;
    logic          rsp_err, rsp_timeout, busy;

    streamcalc_issuer #(.DATA_W(DW), .OP_W(OW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .calc_apply(calc_apply), .calc_op(calc_op), .calc_in(calc_in),
        .calc_valid(calc_valid), .calc_err(calc_err), .calc_out(calc_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy)
    );

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    bit stall_seen = 0;

    // Logs gathered every cycle, and the calculator stub's plan/answers.
    cmd_t       app_q[$];
    int         app_cyc[$];
    rsp_t       rsp_q[$];
    int         rspv_cyc[$];
    int         dly_plan[$];
    int         stub_dly_q[$];
    logic [7:0] stub_out_q[$];
    int         stub_delay = 1;
    int         force_out = -1;
    int         cd = 0;
    logic [7:0] pend_out;
    logic       pend_err;
    logic       rsp_v_prev = 1'b0;

    function automatic logic [27:0] out_vec();
        return {cmd_ready, calc_apply, calc_op, calc_in, rsp_valid, rsp_op, rsp_data, rsp_err, rsp_timeout, busy};
    endfunction

    // Host-visible outcome of a command: the calculator must answer within 15 cycles
    // after the apply cycle, otherwise a zero-data timeout response is returned.
    function automatic rsp_t model_rsp(input cmd_t c, input int dly, input logic [7:0] out);
        rsp_t r;
        if (dly < 1 || dly > TIMEOUT - 1) r = '{c.op, 8'h00, 1'b0, 1'b1};
        else                              r = '{c.op, out, (c.op == OP_BAD), 1'b0};
        return r;
    endfunction

    task automatic tick();
        int d;
        if (cmd_valid && cmd_ready) begin end
        if (rsp_valid && rsp_ready) rsp_q.push_back(rsp_t'({rsp_op, rsp_data, rsp_err, rsp_timeout}));
        @(posedge clk);
        #1;
        cyc++;
        calc_valid = 1'b0;
        calc_err   = 1'b0;
        calc_out   = '0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                calc_valid = 1'b1;
                calc_out   = pend_out;
                calc_err   = pend_err;
            end
        end
        if (calc_apply) begin
            app_q.push_back(cmd_t'({calc_op, calc_in}));
            app_cyc.push_back(cyc);
            d = (dly_plan.size() > 0) ? dly_plan.pop_front() : stub_delay;
            pend_out = (force_out >= 0) ? 8'(force_out) : 8'($urandom);
            pend_err = (calc_op == OP_BAD);
            cd = d;
            stub_dly_q.push_back(d);
            stub_out_q.push_back(pend_out);
        end
        if (rsp_valid && !rsp_v_prev) rspv_cyc.push_back(cyc);
        rsp_v_prev = rsp_valid;
    endtask

    task automatic clear_logs();
        app_q.delete(); app_cyc.delete(); rsp_q.delete(); rspv_cyc.delete();
        dly_plan.delete(); stub_dly_q.delete(); stub_out_q.delete();
        cd = 0; force_out = -1; stall_seen = 0;
    endtask

    task automatic send(input cmd_t c);
        int n = 0;
        cmd_valid = 1'b1; cmd_op = c.op; cmd_data = c.data;
        while (!cmd_ready && n < 200) begin tick(); n++; end
        if (!cmd_ready) stall_seen = 1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n, input int budget);
        int k = 0;
        while (rsp_q.size() < n && k < budget) begin tick(); k++; end
        if (rsp_q.size() < n) stall_seen = 1;
    endtask

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.op = 3'($urandom_range(0, 7));
        c.data = 8'($urandom);
        return c;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0;
        calc_valid = 1'b0; calc_err = 1'b0; calc_out = '0; rsp_ready = 1'b0;
        #3;
        n_checks++;
        if (out_vec() !== RST_VEC) begin
            n_fail++; $display("FAIL reset_outputs: got %h want %h", out_vec(), RST_VEC);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick(); tick();
        n_checks++;
        if (out_vec() !== RST_VEC) begin
            n_fail++; $display("FAIL reset_release_idle: got %h want %h", out_vec(), RST_VEC);
        end
    endtask

    task automatic test_single_push();
        cmd_t c;
        int acc_edge;
        clear_logs(); stub_delay = 1; rsp_ready = 1'b1;
        c = '{OP_PUSH, 8'd20};
        send(c); acc_edge = cyc;
        wait_rsp(1, 40);
        repeat (4) tick();
        n_checks++;
        if (app_q.size() != 1 || app_q[0] !== c) begin
            n_fail++; $display("FAIL single_apply: got %0d applies, first %h want one of %h", app_q.size(), (app_q.size() > 0) ? app_q[0] : cmd_t'(0), c);
        end
        n_checks++;
        if (app_cyc.size() < 1 || app_cyc[0] != acc_edge + 1) begin
            n_fail++; $display("FAIL single_apply_latency: got cycle %0d want %0d", (app_cyc.size() > 0) ? app_cyc[0] : -1, acc_edge + 1);
        end
        n_checks++;
        if (rspv_cyc.size() < 1 || app_cyc.size() < 1 || rspv_cyc[0] != app_cyc[0] + 2) begin
            n_fail++; $display("FAIL single_rsp_latency: got cycle %0d want apply+2", (rspv_cyc.size() > 0) ? rspv_cyc[0] : -1);
        end
        n_checks++;
        if (rsp_q.size() < 1 || stub_dly_q.size() < 1 || rsp_q[0] !== model_rsp(c, stub_dly_q[0], stub_out_q[0])) begin
            n_fail++; $display("FAIL single_rsp: got %h want %h", (rsp_q.size() > 0) ? rsp_q[0] : rsp_t'(0), (stub_dly_q.size() > 0) ? model_rsp(c, stub_dly_q[0], stub_out_q[0]) : rsp_t'(0));
        end
        n_checks++;
        if (stall_seen) begin n_fail++; $display("FAIL single_progress: bound expired got stall want none"); end
    endtask

    task automatic test_back_to_back();
        cmd_t all[7];
        int idx, n;
        bit acc;
        clear_logs(); stub_delay = 1; rsp_ready = 1'b0;
        all[0] = rand_cmd();
        for (int i = 1; i < 7; i++) all[i] = rand_cmd();
        send(all[0]);
        n = 0;
        while (!rsp_valid && n < 20) begin tick(); n++; end
        if (!rsp_valid) stall_seen = 1;
        // Response parked: the FIFO alone absorbs the burst.
        idx = 1;
        for (int k = 0; k < 6; k++) begin
            cmd_valid = 1'b1; cmd_op = all[idx].op; cmd_data = all[idx].data;
            n_checks++;
            if (cmd_ready !== (k < DEPTH)) begin
                n_fail++; $display("FAIL burst_ready_%0d: got %b want %b", k, cmd_ready, (k < DEPTH));
            end
            acc = cmd_ready;
            tick();
            if (acc) idx++;
        end
        n_checks++;
        if (app_q.size() != 1) begin
            n_fail++; $display("FAIL burst_no_apply_in_resp: got %0d applies want 1", app_q.size());
        end
        rsp_ready = 1'b1;
        n = 0;
        while (idx < 7 && n < 300) begin
            cmd_op = all[idx].op; cmd_data = all[idx].data;
            acc = cmd_ready;
            tick(); n++;
            if (acc) idx++;
        end
        cmd_valid = 1'b0;
        if (idx < 7) stall_seen = 1;
        wait_rsp(7, 300);
        repeat (4) tick();
        n_checks++;
        if (app_q.size() != 7) begin
            n_fail++; $display("FAIL burst_apply_count: got %0d want 7", app_q.size());
        end
        for (int i = 0; i < 7; i++) begin
            if (i < app_q.size() && i < rsp_q.size()) begin
                n_checks++;
                if (app_q[i] !== all[i]) begin
                    n_fail++; $display("FAIL burst_order_%0d: got %h want %h", i, app_q[i], all[i]);
                end
                n_checks++;
                if (rsp_q[i] !== model_rsp(all[i], stub_dly_q[i], stub_out_q[i])) begin
                    n_fail++; $display("FAIL burst_rsp_%0d: got %h want %h", i, rsp_q[i], model_rsp(all[i], stub_dly_q[i], stub_out_q[i]));
                end
            end
        end
        for (int i = 1; i + 1 < app_cyc.size(); i++) begin
            n_checks++;
            if (app_cyc[i+1] - app_cyc[i] != 4) begin
                n_fail++; $display("FAIL burst_spacing_%0d: got %0d cycles want 4", i, app_cyc[i+1] - app_cyc[i]);
            end
        end
        n_checks++;
        if (stall_seen) begin n_fail++; $display("FAIL burst_progress: bound expired got stall want none"); end
    endtask

    task automatic test_hold();
        cmd_t a, b;
        int n;
        clear_logs(); stub_delay = 3; force_out = 40; rsp_ready = 1'b0;
        a = '{OP_ADD, 8'($urandom)};
        b = '{OP_SUB, 8'($urandom)};
        send(a); send(b);
        n = 0;
        while (!rsp_valid && n < 30) begin tick(); n++; end
        if (!rsp_valid) stall_seen = 1;
        force_out = -1;
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if ({rsp_valid, rsp_op, rsp_data, rsp_err, rsp_timeout} !== {1'b1, OP_ADD, 8'd40, 1'b0, 1'b0}) begin
                n_fail++; $display("FAIL hold_rsp_%0d: got %b/%0d/%0d/%b/%b want 1/0/40/0/0", k, rsp_valid, rsp_op, rsp_data, rsp_err, rsp_timeout);
            end
            n_checks++;
            if (app_q.size() != 1) begin
                n_fail++; $display("FAIL hold_no_apply_%0d: got %0d applies want 1", k, app_q.size());
            end
            tick();
        end
        rsp_ready = 1'b1;
        wait_rsp(2, 60);
        n_checks++;
        if (rsp_q.size() < 2 || rsp_q[0] !== model_rsp(a, 3, 8'd40) || rsp_q[1] !== model_rsp(b, stub_dly_q[1], stub_out_q[1])) begin
            n_fail++; $display("FAIL hold_rsp_pair: got %0d responses, first %h want %h", rsp_q.size(), (rsp_q.size() > 0) ? rsp_q[0] : rsp_t'(0), model_rsp(a, 3, 8'd40));
        end
        n_checks++;
        if (stall_seen) begin n_fail++; $display("FAIL hold_progress: bound expired got stall want none"); end
    endtask

    task automatic test_error();
        cmd_t e, f;
        rsp_t want;
        clear_logs(); stub_delay = 2; rsp_ready = 1'b1;
        e = '{OP_BAD, 8'($urandom)};
        f = '{OP_MUL, 8'($urandom)};
        send(e); send(f);
        wait_rsp(2, 60);
        n_checks++;
        want = (stub_out_q.size() > 0) ? rsp_t'({OP_BAD, stub_out_q[0], 1'b1, 1'b0}) : rsp_t'(0);
        if (rsp_q.size() < 1 || rsp_q[0] !== want) begin
            n_fail++; $display("FAIL error_rsp: got %h want %h", (rsp_q.size() > 0) ? rsp_q[0] : rsp_t'(0), want);
        end
        n_checks++;
        if (app_q.size() != 2 || app_q[1] !== f) begin
            n_fail++; $display("FAIL error_next_issued: got %0d applies want 2 ending %h", app_q.size(), f);
        end
        n_checks++;
        if (rsp_q.size() < 2 || rsp_q[1] !== model_rsp(f, stub_dly_q[1], stub_out_q[1])) begin
            n_fail++; $display("FAIL error_next_rsp: got %h want err-free response for %h", (rsp_q.size() > 1) ? rsp_q[1] : rsp_t'(0), f);
        end
        n_checks++;
        if (stall_seen) begin n_fail++; $display("FAIL error_progress: bound expired got stall want none"); end
    endtask

    task automatic test_timeout();
        cmd_t c[3];
        clear_logs(); rsp_ready = 1'b1;
        dly_plan = '{0, TIMEOUT - 1, TIMEOUT};
        for (int i = 0; i < 3; i++) c[i] = rand_cmd();
        for (int i = 0; i < 3; i++) send(c[i]);
        wait_rsp(3, 200);
        for (int i = 0; i < 3; i++) begin
            if (i < rsp_q.size() && i < rspv_cyc.size()) begin
                n_checks++;
                if (rsp_q[i] !== model_rsp(c[i], stub_dly_q[i], stub_out_q[i])) begin
                    n_fail++; $display("FAIL timeout_rsp_%0d: got %h want %h", i, rsp_q[i], model_rsp(c[i], stub_dly_q[i], stub_out_q[i]));
                end
                n_checks++;
                if (rspv_cyc[i] != app_cyc[i] + TIMEOUT) begin
                    n_fail++; $display("FAIL timeout_latency_%0d: got %0d cycles want %0d", i, rspv_cyc[i] - app_cyc[i], TIMEOUT);
                end
            end
        end
        n_checks++;
        if (rsp_q.size() < 1 || rsp_q[0].to !== 1'b1 || rsp_q[0].data !== 8'h00) begin
            n_fail++; $display("FAIL timeout_flag: got %h want timeout with zero data", (rsp_q.size() > 0) ? rsp_q[0] : rsp_t'(0));
        end
        n_checks++;
        if (stall_seen) begin n_fail++; $display("FAIL timeout_progress: bound expired got stall want none"); end
    endtask

    task automatic test_random();
        cmd_t gen[20];
        int idx, n;
        bit presenting, acc;
        clear_logs();
        for (int i = 0; i < 20; i++) begin
            gen[i] = rand_cmd();
            dly_plan.push_back($urandom_range(0, TIMEOUT));
        end
        idx = 0; n = 0; presenting = 0;
        while ((idx < 20 || rsp_q.size() < 20) && n < 3000) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (!presenting && idx < 20 && $urandom_range(0, 1) == 1) presenting = 1;
            cmd_valid = presenting;
            if (presenting) begin cmd_op = gen[idx].op; cmd_data = gen[idx].data; end
            acc = presenting && cmd_ready;
            tick(); n++;
            if (acc) begin idx++; presenting = 0; end
        end
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        if (idx < 20 || rsp_q.size() < 20) stall_seen = 1;
        n_checks++;
        if (app_q.size() != 20) begin
            n_fail++; $display("FAIL random_apply_count: got %0d want 20", app_q.size());
        end
        for (int i = 0; i < 20; i++) begin
            if (i < app_q.size() && i < rsp_q.size()) begin
                n_checks++;
                if (app_q[i] !== gen[i]) begin
                    n_fail++; $display("FAIL random_order_%0d: got %h want %h", i, app_q[i], gen[i]);
                end
                n_checks++;
                if (rsp_q[i] !== model_rsp(gen[i], stub_dly_q[i], stub_out_q[i])) begin
                    n_fail++; $display("FAIL random_rsp_%0d: got %h want %h (delay %0d)", i, rsp_q[i], model_rsp(gen[i], stub_dly_q[i], stub_out_q[i]), stub_dly_q[i]);
                end
            end
        end
        n_checks++;
        if (stall_seen) begin n_fail++; $display("FAIL random_progress: bound expired got stall want none"); end
    endtask

    task automatic test_reset_mid();
        clear_logs(); stub_delay = 0; rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(rand_cmd());
        repeat (3) tick();
        n_checks++;
        if (busy !== 1'b1 || app_q.size() != 1 || rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL midreset_pre: got busy %b applies %0d rsp_valid %b want 1/1/0", busy, app_q.size(), rsp_valid);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_vec() !== RST_VEC) begin
            n_fail++; $display("FAIL midreset_immediate: got %h want %h", out_vec(), RST_VEC);
        end
        #1 rst_n = 1'b1;
        repeat (30) tick();
        n_checks++;
        if (app_q.size() != 1 || rsp_q.size() != 0) begin
            n_fail++; $display("FAIL midreset_no_issue: got %0d applies %0d responses want 1/0", app_q.size(), rsp_q.size());
        end
        n_checks++;
        if (out_vec() !== RST_VEC) begin
            n_fail++; $display("FAIL midreset_idle: got %h want %h", out_vec(), RST_VEC);
        end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_back_to_back();
        test_hold();
        test_error();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/streamcalc_issuer.md
Name: streamcalc_issuer

Overview:
Host-side initiator for the stream calculator. It buffers (op, operand) commands from a host through a valid/ready port and drives the calculator's apply/op/in inputs one command at a time. It then waits for the calculator's response (result or error) and returns it to the host through a second valid/ready port. It sits between the host/test sequencer and the calculator core, and is the only block that drives apply.

Parameters:
DATA_W, 8, operand/result width (matches calculator in/out)
OP_W, 3, opcode width
DEPTH, 4, command FIFO entries (power of 2, >=2)
TIMEOUT, 16, cycles to wait for a calculator response before reporting timeout

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  command accepted when valid&&ready; equals !fifo_full
cmd_op  in  OP_W  opcode (0 add, 1 sub, 2 mul, 3 int div, 4 frac div, 5 push, 6 pop, 7 illegal)
cmd_data  in  DATA_W  operand (meaningful for push; forwarded for all ops)
calc_apply  out  1  one-cycle apply pulse to calculator
calc_op  out  OP_W  opcode to calculator, stable while apply high
calc_in  out  DATA_W  operand to calculator, stable while apply high
calc_valid  in  1  calculator response strobe (result or error)
calc_err  in  1  calculator error flag, qualified by calc_valid
calc_out  in  DATA_W  calculator result, qualified by calc_valid
rsp_valid  out  1  response to host valid
rsp_ready  in  1  host accepts response
rsp_op  out  OP_W  opcode the response belongs to
rsp_data  out  DATA_W  captured result (0 on timeout)
rsp_err  out  1  calculator reported error
rsp_timeout  out  1  no calc_valid within TIMEOUT cycles
busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (async, rst_n=0): FIFO emptied, FSM=IDLE, wait counter=0. All outputs 0 except cmd_ready=1. calc_apply must drop immediately on reset assertion, without waiting for a clock edge.
- FIFO: write on cmd_valid&&cmd_ready. Read only on the IDLE->ISSUE transition. Full: cmd_ready=0 and cmd_valid is ignored. A simultaneous write and read when full is not allowed; cmd_ready stays 0 that cycle. Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if FIFO is non-empty, pop the head into the op/in registers and go to ISSUE.
- ISSUE: calc_apply=1 for exactly this one cycle; calc_op/calc_in hold the registered values. Go to WAIT and clear the counter.
- WAIT: calc_apply=0; calc_op/calc_in hold their values.
  - On calc_valid: capture calc_out and calc_err, set rsp_timeout=0, go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without calc_valid: rsp_data=0, rsp_err=0, rsp_timeout=1, go to RESP.
  - calc_valid in the same cycle as the timeout takes priority (treated as a normal response).
- RESP: rsp_valid=1 with rsp_op/rsp_data/rsp_err/rsp_timeout stable until rsp_ready. On rsp_valid&&rsp_ready, go to IDLE and drop rsp_valid next cycle.
- Back-pressure: no new apply is issued while in RESP, so at most one command is outstanding.
- calc_valid outside WAIT is ignored; no state change.
- Latency: a command accepted at edge N into an empty FIFO with FSM idle produces calc_apply high between edges N+1 and N+2. calc_valid sampled at edge k produces rsp_valid high after edge k.
- Throughput: minimum 4 cycles per command with an immediate response and rsp_ready=1.
- Errors: opcode 7, pop from empty, overflow and divide-by-zero are all forwarded unchanged. The issuer never filters; the calculator's calc_err is relayed as rsp_err. Later queued commands are still issued after an error.
- Commands can be written to the FIFO in any FSM state.

Decomposition:
- Package streamcalc_pkg:
  - opcode constants OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3, OP_FDIV=4, OP_PUSH=5, OP_POP=6, OP_BAD=7
  - DATA_W/OP_W defaults
  - issuer state enum
- One sub-module: streamcalc_cmd_fifo, a synchronous FIFO of {op,data} with full/empty, async active-low reset.

Test Plan:
- Reset then push 20 (op=5, data=20), rsp_ready=1, calculator answers calc_valid 1 cycle after apply: one calc_apply pulse with calc_op=5, calc_in=20; rsp_valid with rsp_op=5, rsp_err=0.
- Burst of 6 pushes with cmd_valid held high: cmd_ready drops after 4 accepted. All 6 are eventually issued in order, with exactly one apply pulse each, 4+ cycles apart.
- Add (op=0) with calculator returning calc_out=40 after 3 cycles, rsp_ready held low 5 cycles: rsp_valid/rsp_data=40 held stable; no second apply until the handshake completes.
- Op 7 forwarded with calculator returning calc_err=1: rsp_err=1, rsp_op=7, rsp_timeout=0. The next queued command is still issued.
- No calc_valid after apply: rsp_timeout=1 and rsp_data=0 exactly TIMEOUT=16 cycles after the apply cycle. Also check calc_valid arriving in the final cycle gives a normal response.
- rst_n pulsed low while in WAIT with 2 commands queued: outputs return to reset values immediately, FIFO is empty, and no apply follows.
